sevenseg_bank: RTL and testbench
================================

// Module: sevenseg_bank
// PURPOSE
// - Parametrised multi-digit successor of the single-digit 7-seg decoder; drives NUM_DIGITS common-anode (active-low) displays.
// - Converts a binary value to decimal with a sequential double-dabble engine, or shows it raw in hex. Adds leading-zero blanking and overflow indication.
// - Sits between game/score logic and the board HEX pins.
// PARAMETERS
// - NUM_DIGITS  6   number of digits driven (1..8)
// - DATA_W      20  width of binary input value
// - BLINK_DIV   25000000  clk cycles per blink half-period (only with SEVENSEG_BLINK_EN)
// PORTS
// - clk        in   1                clock; all state on rising edge
// - rst        in   1                reset, asynchronous, active-high
// - load       in   1                start conversion of data (accepted only when busy=0)
// - data       in   DATA_W           binary value, sampled on accepted load
// - hex_mode   in   1                sampled with load: 1=hex digits, 0=decimal
// - blank_lz   in   1                1=blank leading zeros (live, not sampled)
// - display_en in   1                0=all segments off (live)
// - busy       out  1                conversion in progress
// - done       out  1                one-cycle pulse when segments take new value
// - segments   out  7*NUM_DIGITS     digit i at [7*i+6:7*i], bit order gfe_dcba, 0=lit
// BEHAVIOUR
// - Reset: segments all 1 (blank), busy=0, done=0, shift/BCD regs 0, stored digits 0, stored overflow 0, stored hex_mode 0.
// - Handshake: load with busy=0 accepted; load with busy=1 ignored (no queueing).
// - Decimal: FSM IDLE->CONV->IDLE. Accept: capture data, clear BCD reg (4*NUM_DIGITS bits), busy=1 next cycle.
//   CONV: DATA_W iterations, one per cycle (add 3 to each nibble >=5, then shift left 1).
//   After last shift: digit reg updated, busy=0, done=1. Latency load->done = DATA_W+1 cycles.
// - Overflow (decimal): data >= 10**NUM_DIGITS, checked at accept. All digits show '-' (7'b011_1111); blank_lz ignored.
// - Hex: no CONV state. Digit reg = data nibbles; done pulses 1 cycle after accept; busy stays 0.
//   Overflow if any data bit at or above 4*NUM_DIGITS is 1. Glyphs: A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110.
// - Digit glyphs 0-9 as the existing single-digit decoder: 0=100_0000 1=111_1001 2=010_0100 3=011_0000 4=001_1001 5=001_0010 6=000_0010 7=111_1000 8=000_0000 9=001_0000.
// - segments is registered and recomputed every cycle from: stored digits, stored hex_mode, stored overflow, live blank_lz and live display_en.
//   A blank_lz or display_en change is visible 1 cycle later.
// - Leading-zero blank: digits above the highest nonzero digit show 111_1111. Digit 0 is always shown, so value 0 -> "0".
// - During CONV, segments keep showing the previous value (no flicker).
// - Reset mid-CONV: aborts; busy=0, segments blank, no done pulse.
// - Widths: DATA_W may exceed 4*NUM_DIGITS; the overflow compare uses full DATA_W.
// CONFIGURATION
// - Macro SEVENSEG_BLINK_EN defined:
//   - Adds input port blink (1 bit) and a free-running counter modulo BLINK_DIV with a phase toggle.
//   - While blink=1 and phase=1, segments all 1; phase resets to 0 on rst.
//   - blink=0 -> display steady.
// - Macro not defined: no blink port, no counter; BLINK_DIV unused.
// TESTING (NUM_DIGITS=6, DATA_W=20; use BLINK_DIV=4 in sim)
// - Reset asserted -> segments=42'h3FF_FFFF_FFFF, busy=0, done=0; then display_en=1, no load -> still all blank.
// - Reset and decimal load:
//   - Stimulus: load data=123456, hex_mode=0, blank_lz=0.
//   - busy=1 for 20 cycles; done on cycle 21.
//   - Digits 5..0 = 1,2,3,4,5,6: digit0=000_0010, digit5=111_1001.
// - Leading zeros:
//   - data=42, blank_lz=1 -> digits 5..2=111_1111, digit1=001_1001, digit0=010_0100.
//   - data=0 -> digit0=100_0000, others blank.
//   - blank_lz=0 -> digits 5..2=100_0000.
// - Overflow and hex:
//   - decimal data=1000000 -> every digit 011_1111.
//   - hex_mode=1, data=20'hABCDE -> done 1 cycle after load; digits 4..0 = A,b,C,d,E; digit5 = '0', blank if blank_lz=1.
// - Busy/reset edge cases:
//   - load=1 with data=7 while busy converting 999999 -> result 999999, single done.
//   - rst at cycle 10 of CONV -> busy=0, segments blank, no done.
// - With SEVENSEG_BLINK_EN:
//   - blink=1 -> segments alternate value/all-1s every 4 cycles.
//   - blink=0 -> steady.
//   - display_en=0 -> all-1s next cycle regardless.

Source files
------------

// File: rtl/sevenseg_bank_if.sv
// sevenseg_bank_if: bundles the load/data handshake, live display controls and
// the busy/done/segments outputs of sevenseg_bank.
// Optional build macro: SEVENSEG_BLINK_EN adds the blink input.
interface sevenseg_bank_if #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 20
);
    logic                    load;
    logic [DATA_W-1:0]       data;
    logic                    hex_mode;
    logic                    blank_lz;
    logic                    display_en;
`ifdef SEVENSEG_BLINK_EN
    logic                    blink;
`endif
    logic                    busy;
    logic                    done;
    logic [7*NUM_DIGITS-1:0] segments;

    // Driver side (score logic / testbench)
    modport master (
`ifdef SEVENSEG_BLINK_EN
        output blink,
`endif
        output load, data, hex_mode, blank_lz, display_en,
        input  busy, done, segments
    );

    // Display bank side
    modport slave (
`ifdef SEVENSEG_BLINK_EN
        input  blink,
`endif
        input  load, data, hex_mode, blank_lz, display_en,
        output busy, done, segments
    );
endinterface

// File: rtl/sevenseg_bank.sv
// sevenseg_bank: multi-digit common-anode 7-segment driver. Converts a binary
// value to BCD with a one-bit-per-cycle double-dabble engine (or shows it raw
// in hex), with leading-zero blanking and an all-dash overflow indication.
// Optional build macro: SEVENSEG_BLINK_EN adds a blink input and blink timer.
module sevenseg_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 20,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic            clk,
    input  logic            rst,
    sevenseg_bank_if.slave  bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [6:0] SEG_OFF  = 7'b111_1111;
    localparam logic [6:0] SEG_DASH = 7'b011_1111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

    // Glyph lookup, gfe_dcba, active-low. Decimal mode never produces
    // nibbles above 9; if it did, a dash is safer than a hex letter.
    function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b100_0000;
            4'h1: g = 7'b111_1001;
            4'h2: g = 7'b010_0100;
            4'h3: g = 7'b011_0000;
            4'h4: g = 7'b001_1001;
            4'h5: g = 7'b001_0010;
            4'h6: g = 7'b000_0010;
            4'h7: g = 7'b111_1000;
            4'h8: g = 7'b000_0000;
            4'h9: g = 7'b001_0000;
            4'hA: g = 7'b000_1000;
            4'hB: g = 7'b000_0011;
            4'hC: g = 7'b100_0110;
            4'hD: g = 7'b010_0001;
            4'hE: g = 7'b000_0110;
            default: g = 7'b000_1110;
        endcase
        if (!hex && n > 4'd9) g = SEG_DASH;
        return g;
    endfunction

    typedef enum logic [0:0] {S_IDLE, S_CONV} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;     // something has been converted since reset
    logic               r_ovf;
    logic               r_hex;
    logic               r_ovf_pend;  // overflow of the value being converted
    logic [DATA_W-1:0]  r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   r_dig;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEG_W-1:0]   r_seg;

    logic               w_accept;
    logic               w_last;
    logic               w_dec_ovf;
    logic               w_hex_ovf;
    logic               w_blink_off;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_step;
    logic [BCD_W-1:0]   w_hex_dig;
    logic [BCD_W-1:0]   w_dig_nx;
    logic               w_ovf_nx;
    logic               w_hex_nx;
    logic               w_valid_nx;
    logic [NUM_DIGITS:0] w_zero_above;
    logic [SEG_W-1:0]   w_seg_nx;

    assign w_accept  = bus.load && (r_state == S_IDLE);
    assign w_last    = (r_state == S_CONV) && (r_cnt == CNT_W'(DATA_W - 1));
    assign w_dec_ovf = 64'(bus.data) >= DEC_LIMIT;

    // Hex digits are the low data nibbles; bits beyond the display flag overflow.
    generate
        if (DATA_W > BCD_W) begin : g_hex_wide
            assign w_hex_dig = bus.data[BCD_W-1:0];
            assign w_hex_ovf = |bus.data[DATA_W-1:BCD_W];
        end else if (DATA_W == BCD_W) begin : g_hex_exact
            assign w_hex_dig = bus.data;
            assign w_hex_ovf = 1'b0;
        end else begin : g_hex_narrow
            assign w_hex_dig = {{(BCD_W - DATA_W){1'b0}}, bus.data};
            assign w_hex_ovf = 1'b0;
        end
    endgenerate

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
        end
    endgenerate
    assign w_bcd_step = {w_bcd_adj[BCD_W-2:0], r_shift[DATA_W-1]};

    // Next value of the stored display state; changes only when done fires.
    always_comb begin
        w_dig_nx   = r_dig;
        w_ovf_nx   = r_ovf;
        w_hex_nx   = r_hex;
        w_valid_nx = r_valid;
        if (w_accept && bus.hex_mode) begin
            w_dig_nx   = w_hex_dig;
            w_ovf_nx   = w_hex_ovf;
            w_hex_nx   = 1'b1;
            w_valid_nx = 1'b1;
        end else if (w_last) begin
            w_dig_nx   = w_bcd_step;
            w_ovf_nx   = r_ovf_pend;
            w_hex_nx   = 1'b0;
            w_valid_nx = 1'b1;
        end
    end

    // Control FSM: accepts loads, runs the conversion, commits results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_hex      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_dig      <= '0;
            r_cnt      <= '0;
        end else begin
            r_done  <= 1'b0;
            r_dig   <= w_dig_nx;
            r_ovf   <= w_ovf_nx;
            r_hex   <= w_hex_nx;
            r_valid <= w_valid_nx;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.hex_mode) begin
                            r_done <= 1'b1;
                        end else begin
                            r_shift    <= bus.data;
                            r_bcd      <= '0;
                            r_cnt      <= '0;
                            r_ovf_pend <= w_dec_ovf;
                            r_busy     <= 1'b1;
                            r_state    <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    r_bcd   <= w_bcd_step;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SEVENSEG_BLINK_EN
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BC_W-1:0] r_blink_cnt;
    logic            r_phase;

    // Free-running blink timer; phase flips every BLINK_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BC_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BC_W'(1);
        end
    end
    assign w_blink_off = bus.blink && r_phase;
`else
    logic w_unused_blink_div;
    assign w_unused_blink_div = (BLINK_DIV > 0);
    assign w_blink_off        = 1'b0;
`endif

    // Leading-zero detection: a digit is blankable if it and all above are zero.
    assign w_zero_above[NUM_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
            logic w_lz_blank;
            assign w_zero_above[gi] = w_zero_above[gi+1] && (w_dig_nx[4*gi +: 4] == 4'd0);
            assign w_lz_blank = bus.blank_lz && !w_ovf_nx && (gi != 0) && w_zero_above[gi];
            assign w_seg_nx[7*gi +: 7] =
                (!bus.display_en || !w_valid_nx || w_blink_off) ? SEG_OFF  :
                w_ovf_nx                                        ? SEG_DASH :
                w_lz_blank                                      ? SEG_OFF  :
                glyph(w_dig_nx[4*gi +: 4], w_hex_nx);
        end
    endgenerate

    // Segment register: follows the committed digits in the same cycle as done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_seg <= '1;
        else     r_seg <= w_seg_nx;
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.segments = r_seg;
endmodule

// File: tb/tb_sevenseg_bank.sv
// tb_sevenseg_bank: directed + randomized checks of sevenseg_bank
// (NUM_DIGITS=6, DATA_W=20, BLINK_DIV=4) against an arithmetic display model.
module tb_sevenseg_bank;
    localparam int ND = 6;
    localparam int DW = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sevenseg_bank_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();
    sevenseg_bank #(.NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_tab [16] = '{
        7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
        7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
        7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
        7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110};

    // What the display should currently be showing
    int unsigned shown_val   = 0;
    bit          shown_hex   = 0;
    bit          shown_valid = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    // Display model: digit values by division/shift, blanking by highest nonzero digit.
    function automatic logic [41:0] model(input int unsigned v, input bit hex,
                                          input bit blz, input bit den, input bit valid);
        logic [41:0] s;
        int unsigned d [ND];
        int          hi;
        bit          ovf;
        s = '1;
        if (!den || !valid) return s;
        ovf = hex ? ((v >> (4 * ND)) != 0) : (v >= 1000000);
        hi = 0;
        for (int i = 0; i < ND; i++) begin
            d[i] = hex ? ((v >> (4 * i)) & 15) : ((v / (10 ** i)) % 10);
            if (d[i] != 0) hi = i;
        end
        for (int i = 0; i < ND; i++) begin
            if (ovf)                  s[7*i +: 7] = 7'b011_1111;
            else if (blz && i > hi)   s[7*i +: 7] = 7'b111_1111;
            else                      s[7*i +: 7] = glyph_tab[d[i]];
        end
        return s;
    endfunction

    function automatic logic [41:0] expected_now();
        return model(shown_val, shown_hex, bus.blank_lz, bus.display_en, shown_valid);
    endfunction

    // One accepted load: checks latency, busy length, result and done width.
    task automatic run_load(input int unsigned v, input bit hex, input string tag);
        int n;
        int busy_n;
        logic [19:0] v20;
        v20 = v[19:0];
        bus.data     = v20;
        bus.hex_mode = hex;
        bus.load     = 1'b1;
        step();
        bus.load = 1'b0;
        n = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.busy === 1'b1) busy_n++;
            step();
            n++;
        end
        check({tag, " latency"}, 64'(n), hex ? 64'd1 : 64'd21);
        check({tag, " busy_len"}, 64'(busy_n), hex ? 64'd0 : 64'd20);
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        shown_val   = v;
        shown_hex   = hex;
        shown_valid = 1;
        check({tag, " seg"}, 64'(bus.segments), 64'(expected_now()));
        $display("load %s data=%0d hex=%0d blz=%0d seg=%h", tag, v, hex, bus.blank_lz, bus.segments);
        step();
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int dones;
        int unsigned v;
        bit hx;
        int r;
        rst = 1'b1;
        bus.load = 0; bus.data = '0; bus.hex_mode = 0; bus.blank_lz = 0; bus.display_en = 0;
`ifdef SEVENSEG_BLINK_EN
        bus.blink = 0;
`endif
        step(); step();
        check("reset seg", 64'(bus.segments), 64'h3FF_FFFF_FFFF);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        bus.display_en = 1;
        step(); step();
        check("no load blank", 64'(bus.segments), 64'h3FF_FFFF_FFFF);

        // Decimal conversion
        bus.blank_lz = 0;
        run_load(123456, 0, "dec123456");
        check("digit0 six", 64'(bus.segments[6:0]), 64'(7'b000_0010));
        check("digit5 one", 64'(bus.segments[41:35]), 64'(7'b111_1001));

        // Leading zeros
        bus.blank_lz = 1;
        run_load(42, 0, "dec42");
        check("42 upper blank", 64'(bus.segments[41:14]), 64'hFFF_FFFF);
        check("42 digit1", 64'(bus.segments[13:7]), 64'(7'b001_1001));
        check("42 digit0", 64'(bus.segments[6:0]), 64'(7'b010_0100));
        run_load(0, 0, "dec0");
        check("zero digit0", 64'(bus.segments[6:0]), 64'(7'b100_0000));
        bus.blank_lz = 0;
        step();
        check("blz off zeros", 64'(bus.segments), 64'(expected_now()));
        check("blz off digit5", 64'(bus.segments[41:35]), 64'(7'b100_0000));

        // Overflow and hex
        bus.blank_lz = 1;
        run_load(1000000, 0, "dec_ovf");
        check("ovf dashes", 64'(bus.segments), 64'({6{7'b011_1111}}));
        bus.blank_lz = 0;
        run_load(20'hABCDE, 1, "hexABCDE");
        check("hex digit4 A", 64'(bus.segments[34:28]), 64'(7'b000_1000));
        check("hex digit5 0", 64'(bus.segments[41:35]), 64'(7'b100_0000));
        bus.blank_lz = 1;
        step();
        check("hex digit5 blank", 64'(bus.segments[41:35]), 64'(7'b111_1111));

        // display_en is live
        bus.display_en = 0;
        step();
        check("display off", 64'(bus.segments), 64'h3FF_FFFF_FFFF);
        bus.display_en = 1;
        step();
        check("display on", 64'(bus.segments), 64'(expected_now()));

        // Load while busy is ignored
        bus.data = 20'd999999; bus.hex_mode = 0; bus.load = 1;
        step();
        bus.load = 0;
        repeat (4) step();
        bus.data = 20'd7; bus.load = 1;
        step();
        bus.load = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dones++;
            step();
        end
        shown_val = 999999; shown_hex = 0; shown_valid = 1;
        check("busy ignore dones", 64'(dones), 64'd1);
        check("busy ignore seg", 64'(bus.segments), 64'(expected_now()));
        $display("load busy_ignore data=999999 seg=%h dones=%0d", bus.segments, dones);

        // Reset in the middle of a conversion
        bus.data = 20'd555555; bus.load = 1;
        step();
        bus.load = 0;
        repeat (9) step();
        rst = 1'b1;
        #1;
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset seg", 64'(bus.segments), 64'h3FF_FFFF_FFFF);
        check("midreset done", 64'(bus.done), 64'd0);
        step();
        rst = 1'b0;
        shown_valid = 0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done === 1'b1) dones++;
            step();
        end
        check("midreset no done", 64'(dones), 64'd0);
        check("midreset still blank", 64'(bus.segments), 64'h3FF_FFFF_FFFF);
        $display("reset mid-conversion seg=%h dones=%0d", bus.segments, dones);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            hx = 1'($urandom % 2);
            r  = int'($urandom % 4);
            if (hx)          v = $urandom_range(0, 1048575);
            else if (r == 0) v = $urandom_range(1000000, 1048575);
            else if (r == 1) v = $urandom_range(0, 999);
            else             v = $urandom_range(0, 999999);
            bus.blank_lz = 1'($urandom % 2);
            run_load(v, hx, "rand");
            bus.blank_lz = ~bus.blank_lz;
            step();
            check("rand blz toggle", 64'(bus.segments), 64'(expected_now()));
        end

`ifdef SEVENSEG_BLINK_EN
        begin
            int blanks;
            int other;
            bus.blank_lz = 0;
            run_load(314159, 0, "blinkval");
            bus.blink = 1;
            step();
            blanks = 0;
            other  = 0;
            for (int i = 0; i < 16; i++) begin
                if (bus.segments === 42'h3FF_FFFF_FFFF) blanks++;
                else if (bus.segments !== expected_now()) other++;
                step();
            end
            check("blink blank cycles", 64'(blanks), 64'd8);
            check("blink shown value", 64'(other), 64'd0);
            bus.blink = 0;
            step();
            blanks = 0;
            for (int i = 0; i < 8; i++) begin
                if (bus.segments !== expected_now()) blanks++;
                step();
            end
            check("blink off steady", 64'(blanks), 64'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
